// File: rtl/dq_shift_reg.sv
// dq_shift_reg: WIDTH-bit register with enable, mode-selected
// load/shift/rotate/count ops and an LSB-first serial-capture FSM.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  async active-low reset
//   en     op enable (Q holds when 0; FSM DONE still retires)
//   mode   op select, sampled when en=1 in IDLE
//   D      parallel load data
//   si     serial input bit
//   Q      register contents
//   so     serial out: Q[MSB] after left ops, Q[0] otherwise
//   busy   serial capture in progress
//   done   one-cycle pulse ending a capture
//   par    (PARITY_EN only) XOR-reduce of Q
//
// Build option: define PARITY_EN to add the registered par output.

module dq_shift_reg #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             si,
  output logic [WIDTH-1:0] Q,
  output logic             so,
  output logic             busy,
  output logic             done
`ifdef PARITY_EN
  ,
  output logic             par
`endif
);

  localparam int unsigned CW =
    (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROL   = 3'b100,
    M_ROR   = 3'b101,
    M_CNT   = 3'b110,
    M_START = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_DONE    = 2'b10
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  q_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              dir_q;
  logic              dir_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;

  mode_e             mode_s;

  logic [WIDTH-1:0]  shl_v;
  logic [WIDTH-1:0]  shr_v;
  logic [WIDTH-1:0]  rol_v;
  logic [WIDTH-1:0]  ror_v;
  logic [WIDTH-1:0]  inc_v;

  assign mode_s = mode_e'(mode);

  // Candidate results of every datapath op.
  assign shl_v = {q_q[WIDTH-2:0], si};
  assign shr_v = {si, q_q[WIDTH-1:1]};
  assign rol_v = {q_q[WIDTH-2:0],
                  q_q[WIDTH-1]};
  assign ror_v = {q_q[0],
                  q_q[WIDTH-1:1]};
  assign inc_v = q_q + WIDTH'(1);

  // Idle-mode operation decode.
  logic [WIDTH-1:0]  op_q;
  logic              op_dir;
  logic              op_start;

  always_comb begin
    op_q     = q_q;
    op_dir   = dir_q;
    op_start = 1'b0;
    unique case (mode_s)
      M_HOLD: begin
        op_q = q_q;
      end
      M_LOAD: begin
        op_q = D;
      end
      M_SHL: begin
        op_q   = shl_v;
        op_dir = 1'b1;
      end
      M_SHR: begin
        op_q   = shr_v;
        op_dir = 1'b0;
      end
      M_ROL: begin
        op_q   = rol_v;
        op_dir = 1'b1;
      end
      M_ROR: begin
        op_q   = ror_v;
        op_dir = 1'b0;
      end
      M_CNT: begin
        op_q = inc_v;
      end
      M_START: begin
        op_start = 1'b1;
      end
    endcase
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          q_d   = op_q;
          dir_d = op_dir;
          if (op_start) begin
            // Start edge only arms the
            // capture; no shift here.
            state_d = S_CAPTURE;
            cnt_d   = '0;
          end
        end
      end
      S_CAPTURE: begin
        if (en) begin
          q_d   = shr_v;
          dir_d = 1'b0;
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_d = (state_d == S_CAPTURE);
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= RESET_VAL;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PARITY_EN
  logic par_q;

  // Parity of the value being written,
  // so par tracks the current Q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= ^RESET_VAL;
    end else begin
      par_q <= ^q_d;
    end
  end

  assign par = par_q;
`endif

  assign Q    = q_q;
  assign busy = busy_q;
  assign done = done_q;

  // dir_q: 1 = last op moved left.
  assign so = dir_q ? q_q[WIDTH-1]
                    : q_q[0];

endmodule

// File: tb/tb_dq_shift_reg.sv
// tb_dq_shift_reg: directed + randomized bench for dq_shift_reg
// against an arithmetic reference model.

module tb_dq_shift_reg;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] D;
  logic         si;
  logic [W-1:0] Q;
  logic         so;
  logic         busy;
  logic         done;
`ifdef PARITY_EN
  logic         par;
`endif

  int n_chk;
  int n_err;

  // Reference model state.
  int m_q;
  bit m_left;
  int m_phase;
  int m_bits;

  int busy_cnt;
  int done_cnt;

  dq_shift_reg #(
    .WIDTH(W),
    .RESET_VAL('0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .mode (mode),
    .D    (D),
    .si   (si),
    .Q    (Q),
    .so   (so),
    .busy (busy),
    .done (done)
`ifdef PARITY_EN
    ,
    .par  (par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    m_q     = 0;
    m_left  = 0;
    m_phase = 0;
    m_bits  = 0;
  endtask

  // phase: 0 idle, 1 capturing, 2 done
  task automatic mdl_step(
    input bit e,
    input int md,
    input int d,
    input bit s
  );
    case (m_phase)
      0: if (e) begin
        case (md)
          1: m_q = d;
          2: begin
            m_q = (m_q * 2 + s) % M;
            m_left = 1;
          end
          3: begin
            m_q = m_q / 2 + s * (M / 2);
            m_left = 0;
          end
          4: begin
            m_q = (m_q * 2 + m_q / (M / 2)) % M;
            m_left = 1;
          end
          5: begin
            m_q = m_q / 2 + (m_q % 2) * (M / 2);
            m_left = 0;
          end
          6: m_q = (m_q + 1) % M;
          7: begin
            m_phase = 1;
            m_bits = 0;
          end
          default: ;
        endcase
      end
      1: if (e) begin
        m_q = m_q / 2 + s * (M / 2);
        m_left = 0;
        m_bits++;
        if (m_bits == W) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    int exp_so;
    exp_so = m_left ? (m_q / (M / 2)) % 2
                    : m_q % 2;
    check({tag, ".Q"}, 32'(Q), 32'(m_q));
    check({tag, ".so"}, 32'(so), 32'(exp_so));
    check({tag, ".busy"}, 32'(busy),
          32'(m_phase == 1));
    check({tag, ".done"}, 32'(done),
          32'(m_phase == 2));
`ifdef PARITY_EN
    check({tag, ".par"}, 32'(par),
          32'($countones(m_q) % 2));
`endif
  endtask

  // Drive one cycle, then check 1 time unit
  // after the rising edge.
  task automatic tick(
    input bit    e,
    input int    md,
    input int    d,
    input bit    s,
    input string tag
  );
    en   = e;
    mode = 3'(md);
    D    = W'(d);
    si   = s;
    mdl_step(e, md, d, s);
    @(posedge clk);
    #1;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    check_all(tag);
  endtask

  // Async reset pulse between edges.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    mdl_reset();
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    busy_cnt = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 3'b000;
    D        = '0;
    si       = 1'b0;
    mdl_reset();

    #13;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a capture.
    tick(1, 7, 0, 0, "mid.start");
    tick(1, 0, 0, 1, "mid.b0");
    tick(1, 0, 0, 0, "mid.b1");
    check("mid.Q_pre", 32'(Q), 32'h4);
    async_reset("mid.rst");
    check("mid.Q_post", 32'(Q), 32'h0);
    tick(1, 1, 3, 0, "mid.idle_load");
    check("mid.back_idle", 32'(Q), 32'h3);

    // Load and enable.
    tick(1, 1, 'b1010, 0, "load");
    check("load.val", 32'(Q), 32'hA);
    tick(0, 1, 'b0101, 0, "en0");
    check("en0.hold", 32'(Q), 32'hA);

    // Shifts / rotate and so.
    tick(1, 2, 0, 1, "shl");
    check("shl.val", 32'(Q), 32'h5);
    check("shl.so", 32'(so), 32'h0);
    tick(1, 3, 0, 1, "shr");
    check("shr.val", 32'(Q), 32'hA);
    check("shr.so", 32'(so), 32'h0);
    tick(1, 5, 0, 0, "ror");
    check("ror.val", 32'(Q), 32'h5);

    // Count wrap.
    tick(1, 1, 'b1110, 0, "cload");
    tick(1, 6, 0, 0, "cnt1");
    check("cnt1.val", 32'(Q), 32'hF);
    tick(1, 6, 0, 0, "cnt2");
    check("cnt2.val", 32'(Q), 32'h0);
    tick(1, 6, 0, 0, "cnt3");
    check("cnt3.val", 32'(Q), 32'h1);

    // Capture 1,0,1,1 with a stall.
    busy_cnt = 0;
    done_cnt = 0;
    tick(1, 7, 0, 0, "cap.start");
    tick(1, 7, 0, 1, "cap.b0");
    tick(1, 2, 0, 0, "cap.b1");
    tick(0, 7, 0, 1, "cap.stall");
    tick(1, 7, 0, 1, "cap.b2");
    tick(1, 1, 0, 1, "cap.b3");
    check("cap.val", 32'(Q), 32'hD);
    check("cap.done", 32'(done), 32'h1);
    tick(1, 7, 0, 0, "cap.in_done");
    check("cap.no_restart", 32'(busy), 32'h0);
    check("cap.Q_hold", 32'(Q), 32'hD);
    tick(0, 0, 0, 0, "cap.idle");
    check("cap.busy_cycles", 32'(busy_cnt), 32'd5);
    check("cap.done_pulses", 32'(done_cnt), 32'd1);

`ifdef PARITY_EN
    tick(1, 1, 'b1011, 0, "par.load");
    check("par.1011", 32'(par), 32'h1);
    tick(1, 6, 0, 0, "par.cnt");
    check("par.1100", 32'(par), 32'h0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      int e;
      int md;
      int dd;
      int ss;
      e  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      md = $urandom_range(0, 7);
      dd = $urandom_range(0, M - 1);
      ss = $urandom_range(0, 1);
      tick(1'(e), md, dd, 1'(ss), "rnd");
      if ($urandom_range(0, 60) == 0)
        async_reset("rnd.rst");
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
